// File: rtl/datapath_pkg.sv
// Shared constants and ALU operation encoding for the three-stage datapath pipeline.
package datapath_pkg;

  localparam int unsigned DP_WIDTH     = 16;
  localparam int unsigned DP_NREGS     = 8;
  localparam int unsigned DP_MEM_DEPTH = 256;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_NOR   = 4'h5,
    ALU_SLL   = 4'h6,
    ALU_SRL   = 4'h7,
    ALU_SRA   = 4'h8,
    ALU_SLT   = 4'h9,
    ALU_SLTU  = 4'hA,
    ALU_PASSB = 4'hB
  } alu_op_e;

endpackage

// File: rtl/datapath_pipe_alu.sv
// Combinational ALU; unused operation codes produce zero, arithmetic wraps.
module alu_p
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DP_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;

  always_comb begin
    shamt  = b[SH_W-1:0];
    result = '0;
    case (alu_op_e'(alu_sel))
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOR:   result = ~(a | b);
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $signed(a) >>> shamt;
      ALU_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/datapath_pipe.sv
// Three-stage EX/MEM/WB datapath with register file, data memory, forwarding
// and a one-cycle load-use stall.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH     = DP_WIDTH,
  parameter int unsigned NREGS     = DP_NREGS,
  parameter int unsigned MEM_DEPTH = DP_MEM_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     rf_write,
  input  logic                     mem_write,
  input  logic                     mem_sel,
  input  logic                     imm_sel,
  input  logic [$clog2(NREGS)-1:0] rs_addr,
  input  logic [$clog2(NREGS)-1:0] rt_addr,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  input  logic [WIDTH-1:0]         imm_data,
  input  logic [3:0]               alu_sel,
  output logic [WIDTH-1:0]         rlast_data,
  output logic [WIDTH-1:0]         read_data,
  output logic                     zero_flag,
  output logic                     pos_flag
);

  localparam int unsigned RA_W = $clog2(NREGS);
  localparam int unsigned MA_W = $clog2(MEM_DEPTH);

  logic [WIDTH-1:0] rf  [NREGS];
  logic [WIDTH-1:0] mem [MEM_DEPTH];

  logic             ms_valid, ms_rf_write, ms_store, ms_load;
  logic [RA_W-1:0]  ms_rd;
  logic [WIDTH-1:0] ms_alu, ms_wdata;

  logic             wb_valid, wb_rf_write, wb_load;
  logic [RA_W-1:0]  wb_rd;
  logic [WIDTH-1:0] wb_alu, wb_result;

  logic             ex_valid, load_use;
  logic [WIDTH-1:0] rs_val, rt_val, op_b, alu_result;
  logic [MA_W-1:0]  mem_addr;

  // A load's data only exists after MEM, so a dependent instruction waits one cycle.
  assign load_use = ms_valid && ms_load && ms_rf_write &&
                    ((ms_rd == rs_addr) || (!imm_sel && (ms_rd == rt_addr)));
  assign in_ready  = reset && !load_use;
  assign ex_valid  = in_valid && in_ready;
  assign wb_result = wb_load ? read_data : wb_alu;
  assign mem_addr  = ms_alu[MA_W-1:0];
  assign rlast_data = rf[RA_W'(NREGS-1)];

  always_comb begin
    rs_val = rf[rs_addr];
    if (ms_valid && ms_rf_write && !ms_load && (ms_rd == rs_addr))
      rs_val = ms_alu;
    else if (wb_valid && wb_rf_write && (wb_rd == rs_addr))
      rs_val = wb_result;

    rt_val = rf[rt_addr];
    if (ms_valid && ms_rf_write && !ms_load && (ms_rd == rt_addr))
      rt_val = ms_alu;
    else if (wb_valid && wb_rf_write && (wb_rd == rt_addr))
      rt_val = wb_result;

    op_b = imm_sel ? imm_data : rt_val;
  end

  alu_p #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a       (rs_val),
    .b       (op_b),
    .alu_sel (alu_sel),
    .result  (alu_result)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      ms_valid    <= 1'b0;
      ms_rf_write <= 1'b0;
      ms_store    <= 1'b0;
      ms_load     <= 1'b0;
      ms_rd       <= '0;
      ms_alu      <= '0;
      ms_wdata    <= '0;
      wb_valid    <= 1'b0;
      wb_rf_write <= 1'b0;
      wb_load     <= 1'b0;
      wb_rd       <= '0;
      wb_alu      <= '0;
      zero_flag   <= 1'b0;
      pos_flag    <= 1'b0;
    end else begin
      ms_valid    <= ex_valid;
      ms_rf_write <= rf_write;
      ms_store    <= mem_write;
      ms_load     <= mem_sel;
      ms_rd       <= rd_addr;
      ms_alu      <= alu_result;
      ms_wdata    <= rs_val;
      wb_valid    <= ms_valid;
      wb_rf_write <= ms_rf_write;
      wb_load     <= ms_load;
      wb_rd       <= ms_rd;
      wb_alu      <= ms_alu;
      if (ex_valid) begin
        zero_flag <= (alu_result == '0);
        pos_flag  <= ~alu_result[WIDTH-1];
      end
    end
  end

  // Memory contents survive reset; only the write is suppressed while reset is low.
  always_ff @(posedge clock) begin
    if (reset && ms_valid && ms_store)
      mem[mem_addr] <= ms_wdata;
  end

  // The synchronous read register doubles as the WB-stage load data.
  always_ff @(posedge clock) begin
    if (!reset)
      read_data <= '0;
    else if (ms_valid && ms_load)
      read_data <= mem[mem_addr];
  end

  always_ff @(posedge clock) begin
    if (!reset)
      rf <= '{default: '0};
    else if (wb_valid && wb_rf_write)
      rf[wb_rd] <= wb_result;
  end

endmodule

// File: tb/tb_datapath_pipe.sv
// Scoreboard bench: an in-order ISA model predicts flags, rlast_data and read_data
// with their pipeline latencies; a negedge monitor compares them every cycle.
module tb_datapath_pipe;
  import datapath_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned NR = 8;
  localparam int unsigned MD = 256;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          in_valid, in_ready, rf_write, mem_write, mem_sel, imm_sel;
  logic [2:0]    rs_addr, rt_addr, rd_addr;
  logic [W-1:0]  imm_data, rlast_data, read_data;
  logic [3:0]    alu_sel;
  logic          zero_flag, pos_flag;

  logic          w_in_valid, w_in_ready, w_rf_write, w_mem_write, w_mem_sel, w_imm_sel;
  logic [3:0]    w_rs, w_rt, w_rd, w_alu_sel;
  logic [31:0]   w_imm, w_rlast, w_read;
  logic          w_zero, w_pos;

  datapath_pipe #(.WIDTH(W), .NREGS(NR), .MEM_DEPTH(MD)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rf_write(rf_write), .mem_write(mem_write), .mem_sel(mem_sel), .imm_sel(imm_sel),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .imm_data(imm_data),
    .alu_sel(alu_sel), .rlast_data(rlast_data), .read_data(read_data),
    .zero_flag(zero_flag), .pos_flag(pos_flag)
  );

  datapath_pipe #(.WIDTH(32), .NREGS(16), .MEM_DEPTH(64)) dut_wide (
    .clock(clock), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .rf_write(w_rf_write), .mem_write(w_mem_write), .mem_sel(w_mem_sel), .imm_sel(w_imm_sel),
    .rs_addr(w_rs), .rt_addr(w_rt), .rd_addr(w_rd), .imm_data(w_imm),
    .alu_sel(w_alu_sel), .rlast_data(w_rlast), .read_data(w_read),
    .zero_flag(w_zero), .pos_flag(w_pos)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    int          kind;  // 0 flags {zero,pos}, 1 rlast_data, 2 read_data
    logic [31:0] val;
  } exp_t;

  exp_t         sb[$];
  int           edges = 0;
  bit           mon_en;
  logic         cur_zero, cur_pos;
  logic [W-1:0] cur_rlast, cur_rd;

  logic [W-1:0] rf_m  [NR];
  logic [W-1:0] mem_m [MD];
  bit           prev_load;
  logic [2:0]   prev_rd;

  always @(posedge clock) edges <= edges + 1;

  always @(negedge clock) begin
    if (mon_en) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == edges) begin
          case (sb[i].kind)
            0:       begin cur_zero = sb[i].val[1]; cur_pos = sb[i].val[0]; end
            1:       cur_rlast = sb[i].val[W-1:0];
            default: cur_rd = sb[i].val[W-1:0];
          endcase
          sb.delete(i);
        end
      end
      check("zero_flag",  32'(zero_flag),  32'(cur_zero));
      check("pos_flag",   32'(pos_flag),   32'(cur_pos));
      check("rlast_data", 32'(rlast_data), 32'(cur_rlast));
      check("read_data",  32'(read_data),  32'(cur_rd));
    end
  end

  function automatic void push_exp(input int due, input int kind, input logic [31:0] val);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endfunction

  function automatic logic [W-1:0] alu_m(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [3:0] sh;
    sh = b[3:0];
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~(a | b);
      4'h6: return a << sh;
      4'h7: return a >> sh;
      4'h8: return W'($signed(a) >>> sh);
      4'h9: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'hA: return (a < b) ? W'(1) : W'(0);
      4'hB: return b;
      default: return '0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input int rs, input int rt, input int rd,
                       input logic [W-1:0] imm, input bit isimm, input bit wr,
                       input bit st, input bit ld, input bit doomed);
    logic [W-1:0] a, b, res, ld_val, wbv;
    bit exp_stall, accepted;
    int tries, e;
    in_valid = 1'b1; alu_sel = op; imm_data = imm; imm_sel = isimm;
    rf_write = wr; mem_write = st; mem_sel = ld;
    rs_addr = 3'(rs); rt_addr = 3'(rt); rd_addr = 3'(rd);
    accepted = 1'b0;
    tries = 0;
    while (!accepted && tries < 4) begin
      exp_stall = prev_load && ((prev_rd == 3'(rs)) || (!isimm && (prev_rd == 3'(rt))));
      @(negedge clock);
      check("in_ready", 32'(in_ready), 32'(!exp_stall));
      if (in_ready) accepted = 1'b1;
      @(posedge clock); #1;
      prev_load = 1'b0;
      tries++;
    end
    in_valid = 1'b0;
    check("accept_bound", 32'(accepted), 32'd1);
    if (!accepted) return;
    e = edges;
    if (!doomed) begin
      a   = rf_m[rs];
      b   = isimm ? imm : rf_m[rt];
      res = alu_m(op, a, b);
      push_exp(e, 0, {30'b0, (res == '0), ~res[W-1]});
      ld_val = mem_m[res[7:0]];
      if (st) mem_m[res[7:0]] = a;
      if (ld) push_exp(e + 1, 2, 32'(ld_val));
      wbv = ld ? ld_val : res;
      if (wr) begin
        rf_m[rd] = wbv;
        if (rd == NR - 1) push_exp(e + 2, 1, 32'(wbv));
      end
    end
    prev_load = ld && wr;
    prev_rd   = 3'(rd);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
      prev_load = 1'b0;
    end
  endtask

  task automatic alu_rr(input logic [3:0] op, input int rs, input int rt, input int rd);
    issue(op, rs, rt, rd, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu_ri(input logic [3:0] op, input int rs, input logic [W-1:0] imm, input int rd);
    issue(op, rs, 0, rd, imm, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic copy7(input int rs);
    alu_ri(ALU_OR, rs, '0, 7);
  endtask

  task automatic store(input int rs, input logic [W-1:0] addr, input bit doomed);
    issue(ALU_PASSB, rs, 0, 0, addr, 1'b1, 1'b0, 1'b1, 1'b0, doomed);
  endtask

  task automatic load(input int rd, input logic [W-1:0] addr, input bit doomed);
    issue(ALU_PASSB, 0, 0, rd, addr, 1'b1, 1'b1, 1'b0, 1'b1, doomed);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; rf_write = 1'b0; mem_write = 1'b0; mem_sel = 1'b0;
    imm_sel = 1'b0; rs_addr = '0; rt_addr = '0; rd_addr = '0; imm_data = '0; alu_sel = '0;
    w_in_valid = 1'b0; w_rf_write = 1'b0; w_mem_write = 1'b0; w_mem_sel = 1'b0;
    w_imm_sel = 1'b0; w_rs = '0; w_rt = '0; w_rd = '0; w_imm = '0; w_alu_sel = '0;
    mon_en = 1'b0; prev_load = 1'b0; prev_rd = '0;
    cur_zero = 1'b0; cur_pos = 1'b0; cur_rlast = '0; cur_rd = '0;
    foreach (rf_m[i]) rf_m[i] = '0;
    foreach (mem_m[i]) mem_m[i] = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready),   32'd0);
    check("rst_zero",     32'(zero_flag),  32'd0);
    check("rst_pos",      32'(pos_flag),   32'd0);
    check("rst_rlast",    32'(rlast_data), 32'd0);
    check("rst_read",     32'(read_data),  32'd0);
    check("rst_w_ready",  32'(w_in_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    mon_en = 1'b1;

    // Forwarding from MEM, WB and the register file
    alu_ri(ALU_ADD, 0, 16'd5, 1);
    alu_rr(ALU_ADD, 1, 1, 2);
    copy7(2);
    alu_ri(ALU_ADD, 0, 16'h0030, 3); idle(1); copy7(3);
    alu_ri(ALU_ADD, 0, 16'h0041, 4); idle(2); copy7(4);

    // Store, load, load-use stall via rs and via rt; immediate form must not stall
    store(2, 16'd4, 1'b0);
    load(3, 16'd4, 1'b0);
    alu_rr(ALU_ADD, 3, 3, 4);
    copy7(4);
    load(3, 16'd4, 1'b0);
    issue(ALU_ADD, 0, 3, 6, 16'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    load(3, 16'd4, 1'b0);
    alu_rr(ALU_ADD, 0, 3, 6);
    copy7(6);

    // Load followed by a younger store to the same address, then an older-store load
    load(5, 16'd4, 1'b0);
    store(1, 16'd4, 1'b0);
    load(7, 16'd4, 1'b0);
    copy7(5);

    // Zero and negative results
    alu_rr(ALU_SUB, 1, 1, 1);
    alu_ri(ALU_SUB, 1, 16'd1, 5);
    copy7(5);

    // Bubbles between two instructions
    alu_ri(ALU_ADD, 0, 16'd3, 6);
    idle(3);
    alu_ri(ALU_XOR, 6, 16'h00F0, 7);
    alu_ri(ALU_ADD, 0, 16'h00AB, 7);
    idle(3);

    for (int r = 0; r < 2; r++) begin
      alu_ri(ALU_ADD, 0, W'($urandom), 1);
      alu_ri(ALU_ADD, 0, W'($urandom), 2);
      for (int op = 0; op < 13; op++) alu_rr(4'(op), 1, 2, 7);
    end
    alu_ri(ALU_SUB, 0, 16'h7FFF, 7);
    alu_ri(ALU_ADD, 7, 16'h8000, 7);

    // Reset with a load in WB and a store in MEM
    alu_ri(ALU_ADD, 0, 16'h1234, 1);
    alu_ri(ALU_ADD, 0, 16'h5555, 2);
    store(1, 16'd9, 1'b0);
    idle(4);
    mon_en = 1'b0;
    load(6, 16'd9, 1'b1);
    store(2, 16'd9, 1'b1);
    reset = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check("flush_in_ready", 32'(in_ready),   32'd0);
    check("flush_zero",     32'(zero_flag),  32'd0);
    check("flush_pos",      32'(pos_flag),   32'd0);
    check("flush_rlast",    32'(rlast_data), 32'd0);
    check("flush_read",     32'(read_data),  32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    foreach (rf_m[i]) rf_m[i] = '0;
    sb.delete();
    prev_load = 1'b0;
    cur_zero = 1'b0; cur_pos = 1'b0; cur_rlast = '0; cur_rd = '0;
    mon_en = 1'b1;
    load(7, 16'd9, 1'b0);
    idle(4);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Wide instance: WIDTH=32, NREGS=16, write to r15
    w_in_valid = 1'b1; w_alu_sel = ALU_ADD; w_rs = 4'd0; w_imm = 32'h0000_00AB;
    w_imm_sel = 1'b1; w_rf_write = 1'b1; w_rd = 4'd15;
    @(negedge clock);
    check("w_in_ready", 32'(w_in_ready), 32'd1);
    @(posedge clock); #1;
    w_in_valid = 1'b1; w_rs = 4'd15; w_imm = 32'h8000_0000;
    @(negedge clock);
    check("w_zero_1",  32'(w_zero), 32'd0);
    check("w_pos_1",   32'(w_pos),  32'd1);
    check("w_rlast_e0", w_rlast, 32'd0);
    @(posedge clock); #1;
    w_in_valid = 1'b0;
    @(negedge clock);
    check("w_pos_2",    32'(w_pos), 32'd0);
    check("w_rlast_e1", w_rlast, 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("w_rlast_e2", w_rlast, 32'h0000_00AB);
    @(posedge clock); #1;
    @(negedge clock);
    check("w_rlast_e3", w_rlast, 32'h8000_00AB);
    check("w_read",     w_read,  32'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_pipe.md
DATAPATH_PIPE -- requirements
Module: datapath_pipe

Interface
REQ-001 Parameter WIDTH, default 16, data/ALU/memory word width.
REQ-002 Parameter NREGS, default 8, register count; address width RA_W = clog2(NREGS).
REQ-003 Parameter MEM_DEPTH, default 256, data-memory words; address = low clog2(MEM_DEPTH) bits of ALU result.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-low reset.
REQ-007 in_valid  in  1  control word below is presented this cycle.
REQ-008 in_ready  out  1  datapath accepts the control word this cycle.
REQ-009 rf_write, mem_write, mem_sel, imm_sel  in  1 each  RF write, memory store, load select, immediate select.
REQ-010 rs_addr, rt_addr, rd_addr  in  RA_W each  source/destination registers.
REQ-011 imm_data  in  WIDTH  immediate operand.
REQ-012 alu_sel  in  4  ALU operation.
REQ-013 rlast_data  out  WIDTH  contents of register NREGS-1.
REQ-014 read_data  out  WIDTH  last loaded word, registered.
REQ-015 zero_flag, pos_flag  out  1 each  flags of last accepted instruction's ALU result.

Function
REQ-016 Three stages SHALL exist: EX (RF read, forward, ALU), MEM (store or synchronous-read load), WB (RF write); one valid bit per stage.
REQ-017 An instruction SHALL be accepted only on in_valid && in_ready; otherwise a bubble (valid=0) enters MEM.
REQ-018 Bubbles SHALL perform no RF write, no memory write, no flag update.
REQ-019 EX operand B SHALL be imm_data when imm_sel=1, else forwarded rt value.
REQ-020 Forwarding priority per operand: MEM-stage non-load ALU result, then WB-stage result (ALU or load data), then RF; match requires stage valid, rf_write=1, rd equal.
REQ-021 Load-use hazard: MEM stage valid with mem_sel=1, rf_write=1, rd equal to rs_addr, or to rt_addr with imm_sel=0 -> in_ready=0 for exactly one cycle; otherwise in_ready=1.
REQ-022 Store SHALL write forwarded rs value to memory at end of MEM cycle at the ALU-result address.
REQ-023 Load SHALL read memory in MEM with one-cycle latency; data appears in WB and on read_data the cycle after MEM.
REQ-024 read_data SHALL change only when a load reaches WB.
REQ-025 WB SHALL write rd at the rising edge ending WB; write-then-read in the same cycle SHALL be covered by forwarding (REQ-020), so the RF needs no internal bypass.
REQ-026 Acceptance-to-RF-write latency SHALL be 3 cycles; acceptance-to-flags 1 cycle.
REQ-027 zero_flag = (ALU result == 0); pos_flag = ~result[WIDTH-1]; both registered at end of EX for accepted instructions only.
REQ-028 Arithmetic SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-029 Simultaneous store and load to the same address in different stages: the load in MEM SHALL return pre-store data only if the store is younger.

Reset
REQ-030 reset=0 at a rising edge SHALL clear all stage valids, all registers to 0, read_data=0, zero_flag=0, pos_flag=0.
REQ-031 Memory contents SHALL be unaffected by reset.
REQ-032 Reset mid-pipeline SHALL discard in-flight instructions with no RF write; a store in MEM that cycle SHALL not write.
REQ-033 in_ready SHALL be 0 while reset=0.

Structure
REQ-034 Package datapath_pkg SHALL hold the alu_sel operation encoding and the default WIDTH/NREGS/MEM_DEPTH constants.
REQ-035 One sub-module alu_p (combinational, WIDTH-parameterised) SHALL implement the ALU; RF, memory and pipeline registers are inline.

Verification
REQ-036 Reset, then ADD-imm r1=0+5, r2=r1+r1 back-to-back -> r2=10, in_ready stays 1, no stall.
REQ-037 Store r2 (10) to addr 4, load r3 from addr 4, then r4=r3+r3 immediately -> in_ready=0 one cycle, r4=20, read_data=10.
REQ-038 r1=0 via SUB r1,r1 -> zero_flag=1, pos_flag=1; r5 = 0 minus 1 -> zero_flag=0, pos_flag=0, r5=16'hFFFF.
REQ-039 in_valid=0 for 3 cycles between two instructions -> no RF/memory/flag changes during gap.
REQ-040 Assert reset with load and store in flight -> no RF write, stored address unchanged, all outputs 0.
REQ-041 Writes to register NREGS-1 (value 16'h00AB) -> rlast_data=16'h00AB 3 cycles after acceptance; repeat with WIDTH=32, NREGS=16.
